// File: rtl/profile_ci_pkg.sv
// Shared constants for the profiling custom instruction: counter geometry
// and the field layout of the CI write operand (valueB).
package profile_ci_pkg;

  localparam int CNT_W     = 32;
  localparam int NUM_CNT   = 4;
  localparam int CNT_SEL_W = $clog2(NUM_CNT);

  // valueB mask fields, bit i of each field addresses counter i
  localparam int EN_LSB  = 0;
  localparam int DIS_LSB = 4;
  localparam int CLR_LSB = 8;

endpackage

// File: rtl/profile_ci_if.sv
// CPU custom-instruction bus as seen by the profiling unit.
interface profile_ci_if;
  import profile_ci_pkg::*;

  logic             start;
  logic [7:0]       ciN;
  logic [31:0]      valueA;
  logic [31:0]      valueB;
  logic             done;
  logic [CNT_W-1:0] result;

  modport master (output start, ciN, valueA, valueB, input done, result);
  modport slave  (input start, ciN, valueA, valueB, output done, result);

endinterface

// File: rtl/profile_counter.sv
// One profiling channel: enable flop plus a wrapping 32-bit event counter.
module profile_counter
  import profile_ci_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             disable_req,
  input  logic             count_cond,
  input  logic             clear,
  output logic [CNT_W-1:0] value
);

  logic             en_q;
  logic [CNT_W-1:0] cnt_q;

  // Counting uses the pre-edge en_q, so enable/disable land one edge late.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (disable_req)  en_q <= 1'b0;
      else if (enable)  en_q <= 1'b1;

      if (clear)                     cnt_q <= '0;
      else if (en_q && count_cond)   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/profile_ci.sv
// Profiling custom instruction: four event counters controlled and read
// through a single-cycle combinational CI access.
module profile_ci
  import profile_ci_pkg::*;
#(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         busIdle,
  profile_ci_if.slave  ci
);

  logic                             sel;
  logic [NUM_CNT-1:0]               cond;
  logic [NUM_CNT-1:0][CNT_W-1:0]    cnt;
  logic [CNT_SEL_W-1:0]             rd_idx;

  assign sel    = ci.start && (ci.ciN == customId);
  assign rd_idx = ci.valueA[CNT_SEL_W-1:0];

  // Channel events: executing, stalled, bus idle, every cycle.
  assign cond = {1'b1, busIdle, stall, ~stall};

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    profile_counter u_cnt (
      .clock       (clock),
      .reset       (reset),
      .enable      (sel & ci.valueB[EN_LSB+i]),
      .disable_req (sel & ci.valueB[DIS_LSB+i]),
      .count_cond  (cond[i]),
      .clear       (sel & ci.valueB[CLR_LSB+i]),
      .value       (cnt[i])
    );
  end

  assign ci.done = sel;

  always_comb begin
    ci.result = '0;
    if (sel) ci.result = cnt[rd_idx];
  end

  logic unused_bits;
  assign unused_bits = ^{ci.valueA[31:CNT_SEL_W], ci.valueB[31:CLR_LSB+NUM_CNT]};

endmodule

// File: tb/tb_profile_ci.sv
// Directed bench for profile_ci: drives CI accesses on the falling edge and
// checks reads against hand-computed counter values.
module tb_profile_ci;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic stall   = 1'b0;
  logic busIdle = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   nstall;
  logic [31:0] c0, c1, c3, last;

  profile_ci_if ci ();

  profile_ci #(.customId(8'h00)) dut (
    .clock   (clock),
    .reset   (reset),
    .stall   (stall),
    .busIdle (busIdle),
    .ci      (ci)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic access(input logic [7:0] n, input logic [31:0] b);
    ci.start  = 1'b1;
    ci.ciN    = n;
    ci.valueA = 32'h0;
    ci.valueB = b;
    tick(1);
    ci.start  = 1'b0;
    ci.valueB = 32'h0;
  endtask

  // Combinational read inside the low phase; no edge is crossed.
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    ci.start  = 1'b1;
    ci.ciN    = 8'h00;
    ci.valueA = {30'h2AAAAAAA, a};
    ci.valueB = 32'h0;
    #1;
    chk({tag, "_done"}, {31'h0, ci.done}, 32'h1);
    chk(tag, ci.result, exp);
    last     = ci.result;
    ci.start = 1'b0;
  endtask

  initial begin
    ci.start = 1'b0; ci.ciN = 8'h00; ci.valueA = 32'h0; ci.valueB = 32'h0;
    @(negedge clock);
    tick(2);
    reset = 1'b0;

    rd("rst_c0", 2'd0, 32'd0);
    rd("rst_c1", 2'd1, 32'd0);
    rd("rst_c2", 2'd2, 32'd0);
    rd("rst_c3", 2'd3, 32'd0);
    ci.start = 1'b1; ci.ciN = 8'h01; ci.valueA = 32'h3;
    #1;
    chk("other_id_done", {31'h0, ci.done}, 32'h0);
    chk("other_id_result", ci.result, 32'h0);
    ci.start = 1'b0;

    // write to a foreign opcode must not enable anything
    access(8'h01, 32'h00F);
    tick(3);
    rd("foreign_c0", 2'd0, 32'd0);
    rd("foreign_c3", 2'd3, 32'd0);

    // enable counters 0 and 2
    stall = 1'b0; busIdle = 1'b1;
    access(8'h00, 32'h005);
    tick(10);
    rd("en02_c0", 2'd0, 32'd10);
    rd("en02_c2", 2'd2, 32'd10);
    rd("en02_c1", 2'd1, 32'd0);
    rd("en02_c3", 2'd3, 32'd0);

    // enable 1, disable+clear 0, count stalls
    stall = 1'b1; busIdle = 1'b0;
    access(8'h00, 32'h112);
    tick(10);
    rd("stall_c0", 2'd0, 32'd0);
    rd("stall_c1", 2'd1, 32'd10);
    rd("stall_c2", 2'd2, 32'd10);

    // clear beats increment; counter2 counts on the access edge
    busIdle = 1'b1;
    access(8'h00, 32'h224);
    rd("clr1_c1", 2'd1, 32'd0);
    rd("clr1_c2", 2'd2, 32'd11);
    tick(3);
    rd("dis1_c1", 2'd1, 32'd0);
    rd("dis1_c2", 2'd2, 32'd14);

    // clear all, enable all, disable 3
    access(8'h00, 32'hF8F);
    rd("clrall_c0", 2'd0, 32'd0);
    rd("clrall_c1", 2'd1, 32'd0);
    rd("clrall_c2", 2'd2, 32'd0);
    rd("clrall_c3", 2'd3, 32'd0);
    stall = 1'b0; busIdle = 1'b1;
    tick(4);
    rd("resume_c0", 2'd0, 32'd4);
    rd("resume_c1", 2'd1, 32'd0);
    rd("resume_c2", 2'd2, 32'd4);
    rd("resume_c3", 2'd3, 32'd0);

    // wraparound on counter3
    access(8'h00, 32'h008);
    force dut.g_cnt[3].u_cnt.cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.g_cnt[3].u_cnt.cnt_q;
    rd("wrap_pre", 2'd3, 32'hFFFFFFFE);
    tick(3);
    rd("wrap_c3", 2'd3, 32'd1);

    // random stall pattern, counters 0/1/3 enabled and cleared together
    access(8'h00, 32'hB0B);
    nstall = 0;
    for (int k = 0; k < 100; k++) begin
      stall   = 1'($urandom_range(0, 1));
      busIdle = 1'($urandom);
      if (stall) nstall++;
      tick(1);
    end
    rd("rand_c0", 2'd0, 32'(100 - nstall)); c0 = last;
    rd("rand_c1", 2'd1, 32'(nstall));       c1 = last;
    rd("rand_c3", 2'd3, 32'd100);           c3 = last;
    chk("rand_sum", c0 + c1, c3);

    // reset wins over a simultaneous CI write
    reset = 1'b1;
    ci.start = 1'b1; ci.ciN = 8'h00; ci.valueA = 32'h3; ci.valueB = 32'h00F;
    #1;
    chk("rst_done", {31'h0, ci.done}, 32'h1);
    tick(1);
    chk("rst_hold_result", ci.result, 32'h0);
    reset = 1'b0; ci.start = 1'b0; ci.valueB = 32'h0; stall = 1'b0;
    tick(2);
    rd("rstov_c0", 2'd0, 32'd0);
    rd("rstov_c3", 2'd3, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/profile_ci.md
Name: profile_ci

Overview:
- Custom-instruction (CI) profiling unit attached to the CPU custom-instruction interface.
- Holds four 32-bit event counters: CPU-active cycles, stall cycles, bus-idle cycles and total cycles.
- Each counter is individually enabled, disabled and cleared by a CI write.
- Any counter can be read back through the CI result bus.

Parameters:
- customId, 8'h00, CI opcode this block answers to. The block is selected when ciN equals customId.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  CI start strobe from the CPU.
- stall  input  1  CPU stall indicator; high means the CPU is stalled this cycle.
- busIdle  input  1  bus-idle indicator; high means the bus is idle this cycle.
- valueA  input  32  CI operand A; bits [1:0] select the counter to read, bits [31:2] are ignored.
- valueB  input  32  CI operand B; [3:0] enable mask, [7:4] disable mask, [11:8] clear mask, [31:12] ignored. Bit i of each mask addresses counter i.
- ciN  input  8  CI number from the CPU.
- done  output  1  CI completion flag.
- result  output  32  CI read data.

Behaviour:
- Select: sel = start && (ciN == customId).
- CI access is single-cycle and combinational: done = sel in the same cycle.
- result = sel ? counter[valueA[1:0]] : 32'd0. The value returned is the current register value, before this edge's update.
- Enable state: en[3:0] is a register, 0 after reset.
- On a clock edge with sel=1, each en[i] is updated as follows:
  - valueB[4+i]=1 clears it (disable wins over enable).
  - otherwise valueB[i]=1 sets it.
  - otherwise it holds.
- When sel=0, valueB is ignored.
- Count conditions, evaluated with the pre-edge value of en[i]:
  - counter0 increments when en[0] && !stall (CPU executing cycles).
  - counter1 increments when en[1] && stall.
  - counter2 increments when en[2] && busIdle.
  - counter3 increments when en[3] (every cycle).
- Increment is +1, unsigned, wrapping from 32'hFFFFFFFF to 0 with no flag.
- Clear: on an edge with sel=1 and valueB[8+i]=1, counter[i] becomes 0. Clear wins over an increment on the same edge.
- Clear does not change en[i]. If clear and enable are set together, the counter becomes 0 and counts from the next edge.
- Enable takes effect one edge later: the edge that sets en[i] does not itself count.
- Disable takes effect one edge later as well: the edge that clears en[i] still counts if en[i] was 1 and the condition held.
- Reset (synchronous): all counters become 0 and en becomes 4'b0000. Reset overrides any CI action on the same edge.
- While reset is high, done and result still follow their combinational definitions and return 0.
- A read and a write in the same CI access are both performed. The read returns the pre-edge value.

Decomposition:
- Shared package: counter width (32), number of counters (4), and the field offsets of valueB (EN_LSB=0, DIS_LSB=4, CLR_LSB=8). No typedefs are needed.
- One natural sub-module: profile_counter. It is a 32-bit counter with inputs clock, reset, enable, count_cond, clear and output value, and contains the en flip-flop plus the counter.
- Instantiate it four times with the count conditions listed above.
- Top level holds the select decode and the 4:1 result mux.

Test Plan:
- Reset/read: after reset, with start=1, ciN=0, valueA=0..3 -> done=1 and result=0 for each. With ciN=1 -> done=0, result=0.
- Enable 0 and 2: one CI access with valueB=12'h005, then stall=0, busIdle=1 for 10 cycles with valueB=0 -> reading valueA=0 gives 10, valueA=2 gives 10, valueA=1 and valueA=3 give 0.
- Stall counting: continuing from the previous scenario, one access with valueB=12'h112 (enable 1, disable 0, clear 0), then stall=1, busIdle=0 for 10 cycles -> counter0=0, counter1=10, counter2 unchanged (10).
- Disable plus clear priority: one access with valueB=12'h224 (enable 2, disable 1, clear 1) -> the next read of counter1 returns 0 and it stays 0. counter2 keeps counting.
- Clear-all plus total: one access with valueB=12'hF8F -> all counters read 0 on the next cycle. counter3 is disabled (disable wins over enable) and stays 0. counters 0..2 resume from 0.
- Wraparound and randomisation: force counter3 near 32'hFFFFFFFE with 3 enabled cycles -> reads 1. Randomise stall/busIdle over 100 cycles -> counter0 + counter1 equals counter3 when all three were enabled and cleared at the same edge.
